mem_c_deskew: RTL and testbench
===============================

// Module: mem_c_deskew
// PURPOSE
//  Output-side counterpart of the skewed A-input buffer. Captures the diagonally skewed
//  result stream draining from the DIM x DIM systolic array. Column c of row r arrives
//  on capture step r+c. Re-assembles the stream into a row-addressable DIM x DIM matrix.
//  The host then reads the result one full row at a time by row index.
// PARAMETERS
//  BITS_C  24  signed width of each result element
//  DIM     8   array dimension; a capture takes 2*DIM-1 steps
// PORTS
//  clk    in   1                  clock; all state updates on posedge
//  rst_n  in   1                  asynchronous, active-low reset
//  start  in   1                  pulse; begins (or restarts) a capture
//  en     in   1                  capture-step qualifier; one step per cycle with en=1
//  Cin    in   [DIM-1:0][BITS_C]  signed skewed column inputs, Cin[c] from array column c
//  Crow   in   $clog2(DIM)        row index for readback
//  Cout   out  [DIM-1:0][BITS_C]  signed registered row readback
//  busy   out  1                  capture in progress
//  done   out  1                  full matrix captured; readback valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; step counter k=0.
//   - All storage C[r][c]=0; Cout all 0; busy=0; done=0.
//  States:
//   - IDLE    -> CAPTURE on start.
//   - CAPTURE -> READY after the step with k=2*DIM-2 is taken.
//   - READY   -> CAPTURE on start.
//   - start in any state: k<=0, state<=CAPTURE, done<=0 next cycle.
//  Capture steps:
//   - A step is taken in a cycle with state==CAPTURE, en==1 and start==0.
//   - start and en in the same cycle: restart only; no step is taken that cycle.
//   - At step k, for each c with 0 <= k-c <= DIM-1: C[k-c][c] <= Cin[c]; then k <= k+1.
//   - Cin[c] is ignored for c outside that window.
//   - en=0 stalls: k and storage hold.
//   - The first step is the first en=1 cycle after start.
//  busy/done:
//   - busy=1 exactly while state==CAPTURE.
//   - done=1 from the cycle after the final step until the next start or reset.
//   - Storage is not cleared on start; every cell is overwritten during a full capture.
//   - start mid-capture aborts; a partial matrix is never flagged done.
//  Readback:
//   - Cout <= C[Crow] on every posedge while done=1 (1-cycle latency); Cout <= 0 otherwise.
//   - Crow >= DIM (DIM not a power of 2) -> Cout <= 0.
//  Arithmetic: values are stored verbatim; no sign extension, saturation or arithmetic.
// TESTING
//  1. Reset: pulse rst_n low mid-clock -> Cout=0, busy=0, done=0 immediately, no clk edge needed.
//  2. Full capture: start, then 15 en=1 cycles (DIM=8) with Cin[c]=M[k-c][c], M[r][c]=16*r+c.
//     -> done rises after step 14.
//     -> Crow=3 gives Cout={48..55} one cycle later; all 8 rows match M.
//  3. Stalls: same stream with en low for 3 cycles after step 5 and 2 cycles after step 10.
//     -> identical matrix; done one cycle after the 15th en=1 step; busy=1 throughout.
//  4. Abort: start, 6 steps of garbage (Cin=-1), start again, full valid stream.
//     -> matrix equals the second stream; done never asserted between the two starts.
//  5. Out-of-window inputs: during capture drive Cin[c]=24'h7FFFFF whenever k-c is outside 0..7.
//     -> no stored cell equals 24'h7FFFFF.
//     -> negative values (M[r][c]=-(r*8+c)-1) read back sign-exact.
//  6. Re-run and readback gating:
//     - Sweep Crow=0..7 while done -> row-exact Cout, 1-cycle latency.
//     - Start a new capture -> Cout=0 while busy; done clears.

Source files
------------

// File: rtl/mem_c_deskew_if.sv
// -----------------------------------------------------------------------------
// mem_c_deskew_if
//   Bus between the host and the result-deskew buffer for a DIM x DIM systolic
//   array.
//
//   start : pulse that begins, or restarts, a capture
//   en    : capture-step qualifier; each cycle with en=1 takes one step
//   Cin   : signed skewed column inputs; Cin[c] comes from array column c
//   Crow  : row index used for readback
//   Cout  : signed registered row readback
//   busy  : a capture is in progress
//   done  : the full matrix has been captured and readback is valid
//
//   master : host side, drives capture and readback requests
//   slave  : buffer side
// -----------------------------------------------------------------------------
interface mem_c_deskew_if #(
    parameter int BITS_C = 24,
    parameter int DIM    = 8
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

    logic                              start;
    logic                              en;
    logic signed [DIM-1:0][BITS_C-1:0] Cin;
    logic        [RW-1:0]              Crow;
    logic signed [DIM-1:0][BITS_C-1:0] Cout;
    logic                              busy;
    logic                              done;

    modport master (
        output start, en, Cin, Crow,
        input  Cout, busy, done
    );

    modport slave (
        input  start, en, Cin, Crow,
        output Cout, busy, done
    );
endinterface

// File: rtl/mem_c_deskew.sv
// -----------------------------------------------------------------------------
// mem_c_deskew
//   Captures the diagonally skewed result stream that drains from a DIM x DIM
//   systolic array and stores it as a row-addressable matrix. Element (r, c)
//   arrives on Cin[c] during capture step r+c. A full capture therefore takes
//   2*DIM-1 steps. After that the host reads one row per cycle by index.
//
//   clk   : clock; all state changes on the rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : mem_c_deskew_if.slave (start, en, Cin, Crow, Cout, busy, done)
// -----------------------------------------------------------------------------
module mem_c_deskew #(
    parameter int BITS_C = 24,
    parameter int DIM    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_c_deskew_if.slave   bus
);
    localparam int STEPS = 2 * DIM - 1;
    localparam int KW    = $clog2(STEPS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic              busy;
    logic              done;
    logic [BITS_C-1:0] c_mem [DIM][DIM];

    assign bus.busy = busy;
    assign bus.done = done;

    // The control FSM, the storage and the readback register are all kept in
    // this single block, so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bus.Cout <= '0;
            // NOTE: the storage array is small and must read back as zero
            // after reset, so it is reset like the other flops. A RAM macro
            // would not allow this.
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    c_mem[r][c] <= '0;
                end
            end
        end else begin
            // The readback is gated by the current value of done. A row
            // appears one edge after Crow is presented, and the output is zero
            // whenever the matrix is not complete.
            if (done && (int'(bus.Crow) < DIM)) begin
                for (int c = 0; c < DIM; c++) begin
                    bus.Cout[c] <= c_mem[bus.Crow][c];
                end
            end else begin
                bus.Cout <= '0;
            end

            if (bus.start) begin
                // A restart takes priority over a step taken in the same cycle.
                // The storage is not cleared here, because a full capture
                // overwrites every cell.
                state <= CAPTURE;
                k     <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else if (state == CAPTURE && bus.en) begin
                // At step k only the anti-diagonal r+c==k is written. Column
                // inputs outside that window are ignored.
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        if (int'(k) == r + c) begin
                            // NOTE: state registers take non-blocking
                            // assignments, so every read in this block sees
                            // the value from before the edge.
                            c_mem[r][c] <= bus.Cin[c];
                        end
                    end
                end
                k <= k + 1'b1;
                if (k == K_LAST) begin
                    state <= READY;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_c_deskew.sv
// -----------------------------------------------------------------------------
// tb_mem_c_deskew
//   Directed bench for mem_c_deskew with BITS_C=24 and DIM=8. The expected
//   matrices come from closed-form patterns:
//     mode 0: M[r][c] = 16*r + c
//     mode 1: M[r][c] = -(8*r + c) - 1
//   Any input lane outside the active anti-diagonal carries 24'h7FFFFF.
// -----------------------------------------------------------------------------
module tb_mem_c_deskew;
    localparam int BITS_C = 24;
    localparam int DIM    = 8;
    localparam int W      = BITS_C * DIM;
    localparam int STEPS  = 2 * DIM - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_c_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

    mem_c_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sample one time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BITS_C-1:0] mval(input int r, input int c, input int mode);
        if (mode == 0) return BITS_C'(16 * r + c);
        else           return BITS_C'(-(r * 8 + c) - 1);
    endfunction

    function automatic logic [W-1:0] exp_row(input int r, input int mode);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = mval(r, c, mode);
        return v;
    endfunction

    function automatic logic [W-1:0] cin_vec(input int k, input int mode);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < DIM; c++) begin
            if (k - c >= 0 && k - c <= DIM - 1) v[c*BITS_C +: BITS_C] = mval(k - c, c, mode);
            else                                v[c*BITS_C +: BITS_C] = 24'h7FFFFF;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] fill(input logic [BITS_C-1:0] x);
        logic [W-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = x;
        return v;
    endfunction

    task automatic stall(input int n, input string tag);
        bus.en  = 1'b0;
        bus.Cin = fill(24'h123456);
        for (int i = 0; i < n; i++) begin
            cyc();
            check($sformatf("%s_stall_busy%0d", tag, i), W'(bus.busy), W'(1));
            check($sformatf("%s_stall_done%0d", tag, i), W'(bus.done), W'(0));
        end
    endtask

    // Start a capture, then stream the full skewed matrix. Stall bursts of
    // length la and lb are inserted after steps sa and sb. When start_en is
    // set, en=1 is driven together with start; that cycle must not count as a
    // step.
    task automatic run_capture(input int mode, input bit start_en, input int sa, input int la,
                               input int sb, input int lb, input string tag);
        bus.start = 1'b1;
        bus.en    = start_en;
        bus.Cin   = fill(24'h7FFFFF);
        cyc();
        check({tag, "_start_busy"}, W'(bus.busy), W'(1));
        check({tag, "_start_done"}, W'(bus.done), W'(0));
        bus.start = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            bus.en  = 1'b1;
            bus.Cin = cin_vec(k, mode);
            cyc();
            if (k < STEPS - 1) begin
                check($sformatf("%s_busy_k%0d", tag, k), W'(bus.busy), W'(1));
                check($sformatf("%s_done_k%0d", tag, k), W'(bus.done), W'(0));
            end
            if (k == sa) stall(la, tag);
            if (k == sb) stall(lb, tag);
        end
        bus.en  = 1'b0;
        bus.Cin = fill(24'h7FFFFF);
        check({tag, "_end_done"}, W'(bus.done), W'(1));
        check({tag, "_end_busy"}, W'(bus.busy), W'(0));
    endtask

    task automatic read_all(input int mode, input string tag);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < DIM; r++) begin
            bus.Crow = 3'(r);
            cyc();
            check($sformatf("%s_row%0d", tag, r), bus.Cout, exp_row(r, mode));
            for (int c = 0; c < DIM; c++) begin
                if (bus.Cout[c] == 24'h7FFFFF) hit = 1'b1;
            end
        end
        check({tag, "_no_oow_cell"}, W'(hit), W'(0));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.en    = 1'b0;
        bus.Cin   = '0;
        bus.Crow  = '0;

        // Reset state.
        repeat (2) cyc();
        check("rst_cout", bus.Cout, '0);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        rst_n = 1'b1;
        cyc();
        check("idle_busy", W'(bus.busy), W'(0));

        // Full capture without stalls, then read back.
        run_capture(0, 1'b0, -1, 0, -1, 0, "full");
        read_all(0, "full");
        bus.Crow = 3'd2;
        cyc();
        bus.Crow = 3'd3;
        cyc();
        check("row3_latency", bus.Cout, exp_row(3, 0));

        // Asynchronous reset asserted mid-clock, with no edge in between.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_cout", bus.Cout, '0);
        check("async_rst_busy", W'(bus.busy), W'(0));
        check("async_rst_done", W'(bus.done), W'(0));
        #2;
        rst_n = 1'b1;
        cyc();
        check("post_rst_cout", bus.Cout, '0);

        // Stalls after step 5 (3 cycles) and after step 10 (2 cycles).
        run_capture(0, 1'b0, 5, 3, 10, 2, "stall");
        read_all(0, "stall");

        // Negative values; every out-of-window lane carries 7FFFFF.
        run_capture(1, 1'b0, -1, 0, -1, 0, "neg");
        read_all(1, "neg");

        // Abort: 6 steps of -1, then restart with en=1 in the same cycle.
        bus.start = 1'b1;
        bus.en    = 1'b0;
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.en  = 1'b1;
            bus.Cin = fill(24'hFFFFFF);
            cyc();
            check($sformatf("abort_done_k%0d", k), W'(bus.done), W'(0));
        end
        run_capture(0, 1'b1, -1, 0, -1, 0, "restart");
        read_all(0, "restart");

        // Start a new capture: done clears and readback is gated to zero.
        bus.Crow  = 3'd5;
        bus.start = 1'b1;
        bus.en    = 1'b0;
        cyc();
        check("rerun_busy", W'(bus.busy), W'(1));
        check("rerun_done", W'(bus.done), W'(0));
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.en  = i[0];
            bus.Cin = cin_vec(i, 0);
            cyc();
            check($sformatf("rerun_cout%0d", i), bus.Cout, '0);
            check($sformatf("rerun_busy%0d", i), W'(bus.busy), W'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
